// File: rtl/serial_neuron_act.sv
// Bit-serial N-input neuron: LOAD/MAC/ACT pipeline with run-time activation select.
// Define SERIAL_NEURON_SER_OUT_EN to build the LSB-first re-serialiser on out_ser/ser_valid.
module serial_neuron_act #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int FRAC = W - 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] inp,
  input  logic [N-1:0] w,
  input  logic [1:0]   mode,
  output logic         busy,
  output logic [W-1:0] out,
  output logic         rdy,
  output logic         out_ser,
  output logic         ser_valid
);
  localparam int ACCW = 2 * W + $clog2(N);
  localparam int XCW  = FRAC + 2;
  localparam int CW   = $clog2(W + N + 1);
  localparam logic signed [ACCW-1:0] ONE_A     = ACCW'(1 << FRAC);
  localparam logic signed [ACCW-1:0] NEG_ONE_A = ACCW'(-(1 << FRAC));
  localparam logic signed [ACCW-1:0] MAX_A     = ACCW'((1 << (W - 1)) - 1);
  localparam logic signed [ACCW-1:0] MIN_A     = ACCW'(-(1 << (W - 1)));

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_ACT1, S_ACT2} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [W-1:0]            x_q [N];
  logic [W-1:0]            x_d [N];
  logic [W-1:0]            w_q [N];
  logic [W-1:0]            w_d [N];
  logic [1:0]              mode_q, mode_d;
  logic signed [ACCW-1:0]  acc_q, acc_d;
  logic signed [ACCW-1:0]  xs_q, xs_d;
  logic signed [XCW-1:0]   xc_q, xc_d;
  logic signed [XCW-1:0]   sq_q, sq_d;
  logic [W-1:0]            out_q, out_d;
  logic                    rdy_q, rdy_d;

  logic                    shift_en, mac_en;
  logic signed [2*W-1:0]   prod;
  logic signed [ACCW-1:0]  xsh, xcl, y;
  logic signed [XCW-1:0]   xc_w, cube;
  logic signed [2*XCW-1:0] sqf, cubef;
  logic [W-1:0]            ysat;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mode_q  <= '0;
      acc_q   <= '0;
      xs_q    <= '0;
      xc_q    <= '0;
      sq_q    <= '0;
      out_q   <= '0;
      rdy_q   <= 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
        x_q[i] <= '0;
        w_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      acc_q   <= acc_d;
      xs_q    <= xs_d;
      xc_q    <= xc_d;
      sq_q    <= sq_d;
      out_q   <= out_d;
      rdy_q   <= rdy_d;
      x_q     <= x_d;
      w_q     <= w_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    acc_d    = acc_q;
    xs_d     = xs_q;
    xc_d     = xc_q;
    sq_d     = sq_q;
    out_d    = out_q;
    rdy_d    = 1'b0;
    x_d      = x_q;
    w_d      = w_q;
    shift_en = 1'b0;
    mac_en   = 1'b0;

    prod  = $signed(x_q[0]) * $signed(w_q[0]);
    xsh   = acc_q >>> FRAC;
    xcl   = (xsh > ONE_A) ? ONE_A : ((xsh < NEG_ONE_A) ? NEG_ONE_A : xsh);
    xc_w  = XCW'(xcl);
    sqf   = xc_w * xc_w;
    cubef = sq_q * xc_q;
    cube  = XCW'(cubef >>> FRAC);

    unique case (mode_q)
      2'b00:   y = xs_q;
      2'b01:   y = ACCW'(xc_q);
      2'b10:   y = ACCW'(xc_q) + (ACCW'(xc_q) >>> 1) - (ACCW'(cube) >>> 1);
      default: y = xs_q[ACCW-1] ? '0 : xs_q;
    endcase
    ysat = (y > MAX_A) ? MAX_A[W-1:0] : ((y < MIN_A) ? MIN_A[W-1:0] : y[W-1:0]);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_LOAD;
          cnt_d    = CW'(1);
          mode_d   = mode;
          acc_d    = '0;
          shift_en = 1'b1;
        end
      end
      S_LOAD: begin
        shift_en = 1'b1;
        if (cnt_q == CW'(W - 1)) begin
          state_d = S_MAC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_MAC: begin
        mac_en = 1'b1;
        acc_d  = acc_q + ACCW'(prod);
        if (cnt_q == CW'(N - 1)) state_d = S_ACT1;
        else                     cnt_d   = cnt_q + CW'(1);
      end
      S_ACT1: begin
        xs_d    = xsh;
        xc_d    = xc_w;
        sq_d    = XCW'(sqf >>> FRAC);
        state_d = S_ACT2;
      end
      S_ACT2: begin
        out_d   = ysat;
        rdy_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Operands enter at the MSB so bit 0 lands at the LSB after W shifts;
    // during MAC the arrays rotate down so element 0 always feeds the multiplier.
    if (shift_en) begin
      for (int unsigned i = 0; i < N; i++) begin
        x_d[i] = {inp[i], x_q[i][W-1:1]};
        w_d[i] = {w[i], w_q[i][W-1:1]};
      end
    end else if (mac_en) begin
      for (int unsigned i = 0; i + 1 < N; i++) begin
        x_d[i] = x_q[i+1];
        w_d[i] = w_q[i+1];
      end
      x_d[N-1] = '0;
      w_d[N-1] = '0;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign out  = out_q;
  assign rdy  = rdy_q;

`ifdef SERIAL_NEURON_SER_OUT_EN
  logic [W-1:0]  ser_q, ser_d;
  logic [CW-1:0] scnt_q, scnt_d;
  logic          sv_q, sv_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      ser_q  <= '0;
      scnt_q <= '0;
      sv_q   <= 1'b0;
    end else begin
      ser_q  <= ser_d;
      scnt_q <= scnt_d;
      sv_q   <= sv_d;
    end
  end

  // Loaded alongside out so bit 0 is presented in the rdy cycle.
  always_comb begin
    ser_d  = ser_q;
    scnt_d = scnt_q;
    sv_d   = sv_q;
    if (state_q == S_ACT2) begin
      ser_d  = ysat;
      scnt_d = CW'(W - 1);
      sv_d   = 1'b1;
    end else if (sv_q) begin
      ser_d  = ser_q >> 1;
      scnt_d = scnt_q - CW'(1);
      if (scnt_q == '0) sv_d = 1'b0;
    end
  end

  assign out_ser   = ser_q[0] & sv_q;
  assign ser_valid = sv_q;
`else
  assign out_ser   = 1'b0;
  assign ser_valid = 1'b0;
`endif

endmodule

// File: tb/tb_serial_neuron_act.sv
// Scoreboard bench for serial_neuron_act (N=4, W=8, FRAC=6); serial checks follow SERIAL_NEURON_SER_OUT_EN.
module tb_serial_neuron_act;
  localparam int N    = 4;
  localparam int W    = 8;
  localparam int FRAC = 6;
  localparam int ONE  = 64;
  localparam int L    = W + N + 2;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [N-1:0] inp, w;
  logic [1:0]   mode;
  logic         busy, rdy, out_ser, ser_valid;
  logic [W-1:0] out;

  always #5 clk = ~clk;

  serial_neuron_act #(.N(N), .W(W), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .start(start), .inp(inp), .w(w), .mode(mode),
    .busy(busy), .out(out), .rdy(rdy), .out_ser(out_ser), .ser_valid(ser_valid)
  );

  typedef struct { int val; int at; } exp_t;

  exp_t expq[$];
  int   serq[$];
  int   checks = 0, failures = 0;
  int   cyc = 0, act_start = -1, rdy_seen = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  function automatic longint fdiv(input longint a, input longint b);
    return (a >= 0) ? a / b : -((-a + b - 1) / b);
  endfunction

  // Reference: fixed-point arithmetic with floor division on plain integers.
  function automatic int model(input logic [N*W-1:0] xv, input logic [N*W-1:0] wv,
                               input logic [1:0] m);
    longint acc, x, xc, sq, cube, y;
    logic signed [W-1:0] a, b;
    acc = 0;
    for (int i = 0; i < N; i++) begin
      a = xv[i*W +: W];
      b = wv[i*W +: W];
      acc += longint'(a) * longint'(b);
    end
    x  = fdiv(acc, ONE);
    xc = (x > ONE) ? ONE : ((x < -ONE) ? -ONE : x);
    sq = fdiv(xc * xc, ONE);
    case (m)
      2'd0: y = x;
      2'd1: y = xc;
      2'd2: begin
        cube = fdiv(sq * xc, ONE);
        y = xc + fdiv(xc, 2) - fdiv(cube, 2);
      end
      default: y = (x < 0) ? 0 : x;
    endcase
    if (y > 127) y = 127;
    if (y < -128) y = -128;
    return int'(y);
  endfunction

  function automatic logic [N*W-1:0] pack4(input int a, input int b, input int c, input int d);
    return {W'(d), W'(c), W'(b), W'(a)};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    int   o;
    bit   exp_busy;
    if (mon_en) begin
      if (rdy) begin
        rdy_seen++;
        if (expq.size() == 0) begin
          check("unexpected_rdy", 1, 0);
        end else begin
          e = expq.pop_front();
          o = int'($signed(out));
          check("rdy_cycle", cyc, e.at);
          check("out", o, e.val);
`ifdef SERIAL_NEURON_SER_OUT_EN
          for (int k = 0; k < W; k++) serq.push_back((e.val >> k) & 1);
`endif
        end
      end
`ifdef SERIAL_NEURON_SER_OUT_EN
      if (serq.size() > 0) begin
        check("ser_valid", int'(ser_valid), 1);
        check("out_ser", int'(out_ser), serq.pop_front());
      end else begin
        check("ser_valid_idle", int'(ser_valid), 0);
      end
`else
      check("ser_valid_off", int'(ser_valid), 0);
      check("out_ser_off", int'(out_ser), 0);
`endif
      exp_busy = (act_start >= 0) && (cyc >= act_start + 1) && (cyc <= act_start + L - 1);
      check("busy", int'(busy), int'(exp_busy));
    end
  end

  task automatic goto_cycle(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic issue(input logic [N*W-1:0] xv, input logic [N*W-1:0] wv, input logic [1:0] m,
                       input int expv, input int dup_at, input int abort_at);
    int s;
    s = cyc;
    act_start = s;
    if (abort_at < 0) expq.push_back('{expv, s + L});
    start = 1'b1;
    mode  = m;
    for (int k = 0; k < W; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        start = (k == dup_at);
        mode  = 2'($urandom_range(0, 3));
      end
      if (k == abort_at) rst = 1'b1;
      for (int i = 0; i < N; i++) begin
        inp[i] = xv[i*W + k];
        w[i]   = wv[i*W + k];
      end
      if (k == abort_at) begin
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; inp = '0; w = '0;
        act_start = -1;
        return;
      end
    end
    @(posedge clk); #1;
    start = 1'b0; inp = '0; w = '0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((expq.size() > 0 || serq.size() > 0) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (expq.size() > 0 || serq.size() > 0) check("drain_timeout", expq.size() + serq.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N*W-1:0] xv, wv;
    logic [1:0]     m;
    int s, r0;
    rst = 1'b1; start = 1'b0; inp = '0; w = '0; mode = '0;
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b1;
    check("reset_out", int'(out), 0);
    check("reset_rdy", int'(rdy), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_ser_valid", int'(ser_valid), 0);
    check("reset_out_ser", int'(out_ser), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    issue(pack4(64, 0, 0, 0), pack4(64, 0, 0, 0), 2'd0, 64, -1, -1);     drain();
    issue(pack4(32, 0, 0, 0), pack4(64, 0, 0, 0), 2'd2, 44, -1, -1);     drain();
    issue(pack4(-32, 0, 0, 0), pack4(64, 0, 0, 0), 2'd2, -44, -1, -1);   drain();
    issue(pack4(127, 0, 0, 0), pack4(127, 0, 0, 0), 2'd1, 64, -1, -1);   drain();
    issue(pack4(127, 0, 0, 0), pack4(127, 0, 0, 0), 2'd2, 64, -1, -1);   drain();
    issue(pack4(127, 0, 0, 0), pack4(127, 0, 0, 0), 2'd0, 127, -1, -1);  drain();
    issue(pack4(-128, 0, 0, 0), pack4(127, 0, 0, 0), 2'd1, -64, -1, -1); drain();
    issue(pack4(-128, 0, 0, 0), pack4(127, 0, 0, 0), 2'd3, 0, -1, -1);   drain();

    // second start at cycle 5 must be dropped
    issue(pack4(32, 0, 0, 0), pack4(64, 0, 0, 0), 2'd0, 32, 5, -1);      drain();

    r0 = rdy_seen;
    issue(pack4(100, -7, 3, 9), pack4(50, 11, -2, 8), 2'd0, 0, -1, 6);
    check("abort_out", int'(out), 0);
    check("abort_rdy", int'(rdy), 0);
    check("abort_busy", int'(busy), 0);
    repeat (L + W) @(posedge clk);
    #1;
    check("abort_no_rdy", rdy_seen - r0, 0);
    issue(pack4(32, 0, 0, 0), pack4(64, 0, 0, 0), 2'd2, 44, -1, -1);     drain();

    s = cyc;
    issue(pack4(32, 0, 0, 0), pack4(64, 0, 0, 0), 2'd2, 44, -1, -1);
    goto_cycle(s + L);
    issue(pack4(-32, 0, 0, 0), pack4(64, 0, 0, 0), 2'd2, -44, -1, -1);
    drain();

    for (int j = 0; j < 40; j++) begin
      if (j % 2 == 0) begin
        xv = $urandom;
        wv = $urandom;
      end else begin
        for (int i = 0; i < N; i++) begin
          xv[i*W +: W] = W'(int'($urandom_range(0, 48)) - 24);
          wv[i*W +: W] = W'(int'($urandom_range(0, 128)) - 64);
        end
      end
      m = 2'($urandom_range(0, 3));
      s = cyc;
      issue(xv, wv, m, model(xv, wv, m), -1, -1);
      if ($urandom_range(0, 2) == 0) goto_cycle(s + L);
      else                           goto_cycle(s + L + int'($urandom_range(1, 6)));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL global_timeout cycle=%0d actual=running required=finished", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_neuron_act.md
# serial_neuron_act

Parametrised successor to the single-mode serial neuron core: N bit-serial inputs and weights, weighted sum, then one of four run-time-selectable activations (linear, hard clip, cubic sigmoid 1.5x−0.5x³, ReLU). The result is available as a parallel word and, optionally, re-serialised LSB-first. It sits in the neuron layer datapath between the serial operand stream and the next layer's serial inputs.

## Interface
- N, 4: number of input/weight pairs (≥1)
- W, 8: operand and output width, two's complement
- FRAC, W-2: fraction bits; fixed-point value = integer / 2^FRAC; ONE = 2^FRAC
- clk  in  1  clock
- rst  in  1  reset. Synchronous and active-high; the only clock is `clk`.
- start  in  1  one-cycle pulse; the start cycle carries bit 0 of every operand
- inp  in  N  bit-serial inputs, LSB first, bit k in cycle start+k
- w  in  N  bit-serial weights, same timing as `inp`
- mode  in  2  activation select, sampled on the accepted start: 00 linear, 01 clip, 10 cubic, 11 ReLU
- busy  out  1  block is processing; `start` is ignored while high
- out  out  W  result, held until the next result
- rdy  out  1  one-cycle pulse when `out` updates
- out_ser  out  1  `out` re-serialised, LSB first
- ser_valid  out  1  high during the W cycles `out_ser` is valid

## Operation
- FSM states: IDLE → LOAD (W cycles) → MAC (N cycles) → ACT (2 cycles) → IDLE.
- IDLE: `start` is accepted only in IDLE. The block latches `mode` and shifts bit 0 of every operand into its shift registers.
- LOAD: shifts in the remaining operand bits. After W bits total, each x_i and w_i is a W-bit signed value.
- MAC: one product per cycle, i = 0..N-1.
  - acc += x_i·w_i, full precision, ACCW = 2W + clog2(N) bits; no overflow is possible.
- ACT cycle 1:
  - x = acc >>> FRAC (arithmetic shift, truncates toward −∞).
  - xc = x clamped to [−ONE, ONE].
  - sq = (xc·xc) >>> FRAC.
- ACT cycle 2: compute y according to the latched mode.
  - 00 linear: y = x.
  - 01 clip: y = xc.
  - 10 cubic: cube = (sq·xc) >>> FRAC; y = xc + (xc>>>1) − (cube>>>1). For |x| > ONE this yields ±ONE.
  - 11 ReLU: y = max(0, x).
- Output: y is saturated to [−2^(W−1), 2^(W−1)−1], then registered into `out`.
- Serialiser: loads `out` when `rdy` fires and shifts it out LSB first. It is independent of the FSM, so a new operation may start while it runs.
- Reset: `rst` has priority over `start`. It aborts any operation and returns the FSM to IDLE. The partial result is discarded and no `rdy` is produced.
- Reset values:
  - `out` = 0
  - `rdy` = 0
  - `busy` = 0
  - `out_ser` = 0
  - `ser_valid` = 0
  - all internal shift registers, accumulator and serialiser cleared

## Timing
- Cycle numbering: the start cycle is cycle 0.
- LOAD: cycles 0..W−1 (cycle 0 is the IDLE acceptance cycle).
- MAC: cycles W..W+N−1.
- ACT: cycles W+N and W+N+1.
- `out` and `rdy`: valid in cycle W+N+2. Fixed latency L = W+N+2, independent of mode.
- `busy`: high cycles 1..W+N+1. It is low in the `rdy` cycle, so back-to-back starts in that cycle are accepted; throughput is one result per L cycles.
- Serial output: `out_ser`/`ser_valid` present bit k in cycle L+k, k = 0..W−1.
- A new `rdy` always arrives at or after cycle 2L ≥ L+W, so the serialiser never overruns.
- A `start` pulse while `busy` is high is dropped silently; the operation in progress is not disturbed.

## Configuration
- `SERIAL_NEURON_SER_OUT_EN` defined: the serialiser is built and behaves as above.
- Not defined: no serialiser logic is built. `out_ser` and `ser_valid` are tied to 0. `out`, `rdy` and `busy` are unchanged.

## Test plan
All scenarios use N=4, W=8, FRAC=6, so ONE=64; start is issued at cycle 0.
- Mode 00, x=(64,0,0,0), w=(64,0,0,0) → acc=4096, out=64. `rdy` pulses exactly at cycle 14; `busy` is high cycles 1..13.
- Mode 10, x0=32, w0=64, others 0 → x=32, sq=16, cube=8, out=44.
  - Repeat with x0=−32 → out=−44.
- Clip and saturation, x0=w0=127 (x=252):
  - mode 01 → 64
  - mode 10 → 64
  - mode 00 → 127 (saturated)
  - with x0=−128 (x=−254): mode 01 → −64, mode 11 → 0
- Start ignored while busy, then reset mid-operation:
  - Second `start` at cycle 5 → ignored; exactly one `rdy` at cycle 14.
  - Assert `rst` at cycle 6 of a new operation → all outputs 0, no `rdy`.
  - `start` after reset → correct result at L.
- With `SERIAL_NEURON_SER_OUT_EN` defined and out=44 (0b00101100) → `out_ser` = 0,0,1,1,0,1,0,0 in cycles 14..21 with `ser_valid` high.
  - A back-to-back start at cycle 14 yields the next `rdy` at cycle 28.
  - Without the macro, `out_ser` and `ser_valid` stay 0.
